// File: rtl/periph_bus_bridge.sv
// CPU-to-peripheral bridge: decodes one request at a time onto four slave ports,
// with a bounded wait for slave completion and error reporting on timeout/unmapped.
module periph_bus_bridge #(
    parameter logic [31:0] SLV_MASK       = 32'hFFFF_FF00,
    parameter logic [31:0] SLV0_BASE      = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE      = 32'h8000_0100,
    parameter logic [31:0] SLV2_BASE      = 32'h8000_0200,
    parameter logic [31:0] SLV3_BASE      = 32'h8000_0300,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic          cpu_clk,
    input  logic          resetn,
    input  logic          m_valid,
    input  logic [31:0]   m_addr,
    input  logic [31:0]   m_wdata,
    input  logic [3:0]    m_wstrb,
    output logic          m_ready,
    output logic [31:0]   m_rdata,
    output logic [3:0]    s_valid,
    output logic [31:0]   s_addr,
    output logic [31:0]   s_wdata,
    output logic [3:0]    s_wstrb,
    input  logic [3:0]    s_ready,
    input  logic [127:0]  s_rdata,
    output logic          bus_err,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [31:0] m_rdata_q, m_rdata_d;
    logic [3:0]  s_valid_q, s_valid_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        hit;
    logic [1:0]  hit_idx;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    function automatic logic [31:0] slv_base(input int idx);
        case (idx)
            0:       slv_base = SLV0_BASE;
            1:       slv_base = SLV1_BASE;
            2:       slv_base = SLV2_BASE;
            default: slv_base = SLV3_BASE;
        endcase
    endfunction

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((m_addr & SLV_MASK) == slv_base(i)) begin
                hit     = 1'b1;
                hit_idx = i[1:0];
            end
        end
    end

    assign sel_ready = s_ready[sel_q];
    assign sel_rdata = s_rdata[32*sel_q +: 32];

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
            m_rdata_q   <= 32'd0;
            s_valid_q   <= 4'd0;
            s_addr_q    <= 32'd0;
            s_wdata_q   <= 32'd0;
            s_wstrb_q   <= 4'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            m_rdata_q   <= m_rdata_d;
            s_valid_q   <= s_valid_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        m_rdata_d   = m_rdata_q;
        s_valid_d   = s_valid_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wstrb_d   = s_wstrb_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    s_addr_d   = m_addr;
                    s_wdata_d  = m_wdata;
                    s_wstrb_d  = m_wstrb;
                    sel_d      = hit_idx;
                    wait_cnt_d = 8'd0;
                    err_d      = !hit;
                    if (hit) begin
                        s_valid_d = 4'(4'b0001 << hit_idx);
                        state_d   = REQ;
                    end else begin
                        m_rdata_d = ERR_RDATA;
                        state_d   = RESP;
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            REQ: begin
                // A ready arriving on the last allowed cycle still counts as success.
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    s_valid_d = 4'd0;
                    state_d   = RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    m_rdata_d = ERR_RDATA;
                    s_valid_d = 4'd0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_ready   = (state_q == RESP);
    assign bus_err   = (state_q == RESP) && err_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wstrb   = s_wstrb_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: directed vector table, random requests
// against a transaction-level model, and hand sequences for saturation and reset.
module tb_periph_bus_bridge;

    localparam int T     = 64;
    localparam int NEVER = 1000;

    logic          cpu_clk = 1'b0;
    logic          resetn  = 1'b0;
    logic          m_valid = 1'b0;
    logic [31:0]   m_addr  = '0;
    logic [31:0]   m_wdata = '0;
    logic [3:0]    m_wstrb = '0;
    logic          m_ready;
    logic [31:0]   m_rdata;
    logic [3:0]    s_valid;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic [3:0]    s_ready = '0;
    logic [127:0]  s_rdata;
    logic          bus_err;
    logic [7:0]    err_count;

    logic [31:0]   slv_data [4];
    int            slv_dly = NEVER;
    bit            noise   = 1'b0;
    int            vcnt [4];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ecnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly;
        bit          noise;
        logic [31:0] srd;
        logic [3:0]  exp_sval;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    periph_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .cpu_clk   (cpu_clk),
        .resetn    (resetn),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .bus_err   (bus_err),
        .err_count (err_count)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign s_rdata = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

    // Slave model: ready pulses in the REQ cycle numbered slv_dly (0 = first cycle
    // s_valid is seen); unselected slaves optionally drive spurious ready.
    always @(negedge cpu_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (s_valid[i]) begin
                s_ready[i] = (vcnt[i] == slv_dly);
                vcnt[i]    = vcnt[i] + 1;
            end else begin
                s_ready[i] = noise;
                vcnt[i]    = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Transaction-level reference: which slave answers, how long it takes, what comes back.
    function automatic vec_t model(input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [3:0] wstrb, input int dly, input bit nz,
                                   input logic [31:0] srd);
        vec_t v;
        int   idx = -1;
        v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.dly = dly; v.noise = nz; v.srd = srd;
        for (int i = 3; i >= 0; i--)
            if ((addr & 32'hFFFF_FF00) == 32'h8000_0000 + 32'(i * 256)) idx = i;
        if (idx < 0) begin
            v.exp_sval = 4'd0; v.exp_lat = 1; v.exp_rdata = 32'hDEAD_BEEF; v.exp_err = 1'b1;
        end else begin
            v.exp_sval = 4'(1 << idx);
            if (dly < T) begin
                v.exp_lat = dly + 2; v.exp_rdata = srd + 32'(idx); v.exp_err = 1'b0;
            end else begin
                v.exp_lat = T + 1; v.exp_rdata = 32'hDEAD_BEEF; v.exp_err = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        slv_dly = v.dly;
        noise   = v.noise;
        for (int i = 0; i < 4; i++) slv_data[i] = v.srd + 32'(i);
        @(negedge cpu_clk);
        m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb;
        @(posedge cpu_clk); #1;
        chk({tag, " s_valid"}, {28'd0, s_valid}, {28'd0, v.exp_sval});
        chk({tag, " s_addr"},  s_addr, v.addr);
        chk({tag, " s_wdata"}, s_wdata, v.wdata);
        chk({tag, " s_wstrb"}, {28'd0, s_wstrb}, {28'd0, v.wstrb});
        n = 1;
        while (!m_ready && n < T + 10) begin
            @(posedge cpu_clk); #1;
            n++;
        end
        m_valid = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(v.exp_lat));
        chk({tag, " m_rdata"}, m_rdata, v.exp_rdata);
        chk({tag, " bus_err"}, {31'd0, bus_err}, {31'd0, v.exp_err});
        chk({tag, " s_valid_resp"}, {28'd0, s_valid}, 32'd0);
        if (v.exp_err && exp_ecnt < 255) exp_ecnt++;
        @(posedge cpu_clk); #1;
        chk({tag, " m_ready_pulse"}, {31'd0, m_ready}, 32'd0);
        chk({tag, " bus_err_pulse"}, {31'd0, bus_err}, 32'd0);
        chk({tag, " err_count"}, {24'd0, err_count}, 32'(exp_ecnt));
        chk({tag, " m_rdata_hold"}, m_rdata, v.exp_rdata);
        noise = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " m_ready"},   {31'd0, m_ready}, 32'd0);
        chk({tag, " m_rdata"},   m_rdata, 32'd0);
        chk({tag, " s_valid"},   {28'd0, s_valid}, 32'd0);
        chk({tag, " s_addr"},    s_addr, 32'd0);
        chk({tag, " s_wdata"},   s_wdata, 32'd0);
        chk({tag, " s_wstrb"},   {28'd0, s_wstrb}, 32'd0);
        chk({tag, " bus_err"},   {31'd0, bus_err}, 32'd0);
        chk({tag, " err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    initial begin
        int  seen;
        vec_t v;
        for (int i = 0; i < 4; i++) begin slv_data[i] = '0; vcnt[i] = 0; end

        // Directed table: addr, wdata, wstrb, dly, noise, srd, exp_sval, exp_lat, exp_rdata, exp_err
        vecs.push_back('{32'h8000_0000, 32'h0,         4'b0000, 1,     1'b0, 32'h0000_1234, 4'b0001, 3,     32'h0000_1234, 1'b0});
        vecs.push_back('{32'h8000_0104, 32'hA5A5_A5A5, 4'b0011, 1,     1'b0, 32'h0000_1000, 4'b0010, 3,     32'h0000_1001, 1'b0});
        vecs.push_back('{32'h8000_0200, 32'h0,         4'b0000, NEVER, 1'b0, 32'h0000_2000, 4'b0100, T + 1, 32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{32'h9000_0000, 32'h0,         4'b0000, 1,     1'b0, 32'h0000_3000, 4'b0000, 1,     32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{32'h8000_0300, 32'h0,         4'b0000, T - 1, 1'b0, 32'h0000_5000, 4'b1000, T + 1, 32'h0000_5003, 1'b0});
        vecs.push_back('{32'h8000_03FC, 32'h1111_2222, 4'b1111, 0,     1'b1, 32'h0000_7000, 4'b1000, 2,     32'h0000_7003, 1'b0});
        vecs.push_back('{32'h8000_0400, 32'h0,         4'b1000, 0,     1'b1, 32'h0000_8000, 4'b0000, 1,     32'hDEAD_BEEF, 1'b1});
        vecs.push_back('{32'h8000_00FF, 32'h0,         4'b0000, 5,     1'b1, 32'h0000_9000, 4'b0001, 7,     32'h0000_9000, 1'b0});
        vecs.push_back('{32'h8000_0104, 32'h0,         4'b0000, T - 2, 1'b0, 32'h0000_A000, 4'b0010, T,     32'h0000_A001, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0,         4'b0000, 0,     1'b0, 32'h0000_B000, 4'b0000, 1,     32'hDEAD_BEEF, 1'b1});

        resetn = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1;
        chk_all_zero("reset");
        @(negedge cpu_clk);
        resetn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 + 32'($urandom_range(0, 32'h4FF))) : $urandom;
            v = model(a, $urandom, 4'($urandom), int'($urandom_range(0, T + 6)),
                      bit'($urandom_range(0, 1)), $urandom);
            run_vec(v, $sformatf("rnd%0d", k));
        end

        for (int k = 0; k < 300; k++) begin
            v = model(32'h9000_0000 + 32'(k), 32'h0, 4'h0, 0, 1'b0, 32'h0);
            run_vec(v, "sat");
        end
        chk("saturated err_count", {24'd0, err_count}, 32'h0000_00FF);

        // Abandon a transaction mid-wait with a one-cycle reset pulse.
        slv_dly = NEVER;
        @(negedge cpu_clk);
        m_valid = 1'b1; m_addr = 32'h8000_0200; m_wdata = 32'h5555_AAAA; m_wstrb = 4'hF;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        resetn = 1'b0;
        #1;
        chk_all_zero("midreq_reset");
        @(negedge cpu_clk);
        resetn  = 1'b1;
        m_valid = 1'b0;
        exp_ecnt = 0;
        seen = 0;
        for (int c = 0; c < T + 10; c++) begin
            @(posedge cpu_clk); #1;
            if (m_ready || bus_err) seen++;
        end
        chk("post_reset no m_ready", 32'(seen), 32'd0);
        chk("post_reset err_count", {24'd0, err_count}, 32'd0);
        v = model(32'h8000_0000, 32'h0, 4'h0, 1, 1'b0, 32'h0000_1234);
        run_vec(v, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/periph_bus_bridge.md
PERIPH_BUS_BRIDGE -- requirements
Module: periph_bus_bridge

Interface
REQ-001 Parameter SLV_MASK, default 32'hFFFF_FF00, address bits compared during slave decode.
REQ-002 Parameter SLV0_BASE..SLV3_BASE, defaults 32'h8000_0000 / 32'h8000_0100 / 32'h8000_0200 / 32'h8000_0300, decode base of slave 0..3.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, range 2..255, maximum cycles waited for s_ready.
REQ-004 Parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on timeout or unmapped access.
REQ-005 cpu_clk  in  1  single clock; all logic on its rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 m_valid / m_addr / m_wdata / m_wstrb  in  1/32/32/4  CPU-side request, held stable until m_ready.
REQ-008 m_ready / m_rdata  out  1/32  CPU-side completion pulse and read data.
REQ-009 s_valid  out  4  one-hot per-slave request.
REQ-010 s_addr / s_wdata / s_wstrb  out  32/32/4  shared registered request to slaves.
REQ-011 s_ready  in  4  per-slave completion.
REQ-012 s_rdata  in  128  slave i read data on bits [32*i+31:32*i].
REQ-013 bus_err  out  1  one-cycle pulse per failed transaction.
REQ-014 err_count  out  8  saturating count of failed transactions.

Function
REQ-015 FSM states IDLE, REQ, RESP; reset state IDLE.
REQ-016 IDLE: on m_valid=1, register m_addr/m_wdata/m_wstrb into s_addr/s_wdata/s_wstrb and decode; hit -> REQ, no hit -> RESP (error).
REQ-017 Slave i hits when (m_addr & SLV_MASK) == SLVi_BASE; multiple hits resolve to lowest index.
REQ-018 REQ: s_valid[sel]=1, all other s_valid bits 0; s_ready of unselected slaves ignored.
REQ-019 REQ: s_ready[sel]=1 -> capture s_rdata slice of sel into m_rdata, clear s_valid, go RESP.
REQ-020 REQ: wait counter clears on REQ entry, increments each REQ cycle; reaching TIMEOUT_CYCLES-1 with s_ready[sel]=0 -> m_rdata=ERR_RDATA, clear s_valid, go RESP with error.
REQ-021 s_ready[sel] and timeout in same cycle: s_ready wins, no error.
REQ-022 Unmapped access: m_rdata=ERR_RDATA, write dropped, no s_valid asserted, error flagged.
REQ-023 RESP: m_ready=1 for exactly one cycle, then IDLE; bus_err=1 in that same cycle if error.
REQ-024 err_count increments by 1 per error, saturates at 8'hFF.
REQ-025 m_ready never asserted in IDLE or REQ; m_valid in RESP ignored; new request accepted only in IDLE.
REQ-026 Latency: slave with registered ready (ready one cycle after s_valid) -> m_ready 3 cycles after m_valid sampled in IDLE; unmapped -> 1 cycle.
REQ-027 m_rdata holds value until next capture; value for writes is don't-care but deterministic (slave rdata or ERR_RDATA).

Reset
REQ-028 resetn=0 immediately forces: state IDLE, m_ready 0, m_rdata 0, s_valid 0, s_addr/s_wdata/s_wstrb 0, bus_err 0, err_count 0, wait counter 0.
REQ-029 Reset asserted mid-REQ abandons transaction; no m_ready, no error recorded after release.

Verification
REQ-030 Read 0x8000_0000, slave 0 ready 1 cycle after s_valid with rdata 0x0000_1234 -> s_valid=4'b0001, m_ready 3 cycles after m_valid, m_rdata=0x0000_1234, bus_err 0.
REQ-031 Write 0x8000_0104, wdata 0xA5A5_A5A5, wstrb 4'b0011 -> s_valid=4'b0010, s_addr=0x8000_0104, s_wstrb=4'b0011, single m_ready pulse.
REQ-032 Read 0x8000_0200, slave 2 never ready -> m_ready after TIMEOUT_CYCLES REQ cycles, m_rdata=0xDEAD_BEEF, bus_err one pulse, err_count=1.
REQ-033 Read 0x9000_0000 -> no s_valid, m_ready next cycle, m_rdata=0xDEAD_BEEF, bus_err pulse; 300 such accesses -> err_count=8'hFF.
REQ-034 Slave 3 s_ready on exact timeout cycle -> slave data returned, bus_err 0, err_count unchanged.
REQ-035 resetn low for 1 cycle during REQ -> all outputs 0 asynchronously, no m_ready; next request completes normally.
